blake_v_state_seq: RTL

Parametrised, sequenced working-state engine for the BLAKE compression function. It holds the 16-word `v` state, presents G-function operands for the current column/diagonal step, and writes G results back. It generalises the fixed 64-bit, one-G-per-step update logic to configurable word width, number of parallel G lanes and round count, with load/run/drain handshakes. It sits between message/counter initialisation and finalisation; external G units are combinational or pipelined.

---
 rtl/blake_v_state_seq_pkg.sv | 21 ++
 rtl/blake_v_state_seq_g_mux.sv | 28 ++
 rtl/blake_v_state_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/blake_v_state_seq_pkg.sv
// Shared types and helpers for the BLAKE working-state sequencer.
// Provides the word-index mapping that turns a G index into one of its four v words.
package blake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int ROUNDS_512 = 16;
  localparam int ROUNDS_256 = 14;

  // Row 'pos' (a,b,c,d) of G 'g'. Diagonal steps rotate the column by the row number.
  function automatic logic [3:0] g_word_idx(input logic [2:0] g, input logic [1:0] pos);
    logic [1:0] col;
    col = g[2] ? (g[1:0] + pos) : g[1:0];
    return {pos, col};
  endfunction

endpackage

// File: rtl/blake_v_state_seq_g_mux.sv
// Operand selector for one G lane: picks a/b/c/d out of the packed 16-word state.
module blake_g_mux
  import blake_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [16*W-1:0] v_i,
  input  logic [2:0]      g_i,
  output logic [W-1:0]    a_o,
  output logic [W-1:0]    b_o,
  output logic [W-1:0]    c_o,
  output logic [W-1:0]    d_o
);

  logic [W-1:0] words [16];

  for (genvar k = 0; k < 16; k++) begin : g_unpack
    assign words[k] = v_i[(16-k)*W-1 -: W];
  end

  always_comb begin
    a_o = words[g_word_idx(g_i, 2'd0)];
    b_o = words[g_word_idx(g_i, 2'd1)];
    c_o = words[g_word_idx(g_i, 2'd2)];
    d_o = words[g_word_idx(g_i, 2'd3)];
  end

endmodule

// File: rtl/blake_v_state_seq.sv
// BLAKE working-state engine: holds v, sequences column/diagonal G steps over
// NG parallel lanes for ROUNDS rounds, and hands the final state downstream.
module blake_v_state_seq
  import blake_pkg::*;
#(
  parameter  int W      = 64,
  parameter  int NG     = 1,
  parameter  int ROUNDS = 16,
  localparam int RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_valid,
  input  logic [16*W-1:0]   init_v,
  output logic              init_ready,
  output logic              g_op_valid,
  output logic [NG*W-1:0]   g_a,
  output logic [NG*W-1:0]   g_b,
  output logic [NG*W-1:0]   g_c,
  output logic [NG*W-1:0]   g_d,
  output logic [2:0]        g_step,
  output logic [RW-1:0]     g_round,
  input  logic              g_res_valid,
  input  logic [NG*W-1:0]   g_ra,
  input  logic [NG*W-1:0]   g_rb,
  input  logic [NG*W-1:0]   g_rc,
  input  logic [NG*W-1:0]   g_rd,
  output logic              out_valid,
  output logic [16*W-1:0]   out_v,
  input  logic              out_ready
);

  localparam logic [2:0]    NG3        = 3'(NG);
  localparam logic [2:0]    BEAT_LAST  = 3'(8/NG - 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  v_q [16];
  logic [W-1:0]  v_d [16];
  logic [RW-1:0] round_q, round_d;
  logic [2:0]    beat_q, beat_d;
  logic [2:0]    lane_g [NG];
  logic [16*W-1:0] v_flat;
  logic          accept, last_beat, last_round;

  assign accept     = (state_q == ST_RUN) && g_res_valid;
  assign last_beat  = (beat_q == BEAT_LAST);
  assign last_round = (round_q == ROUND_LAST);

  for (genvar k = 0; k < 16; k++) begin : g_pack
    assign v_flat[(16-k)*W-1 -: W] = v_q[k];
  end

  assign out_v   = v_flat;
  assign g_step  = beat_q * NG3;
  assign g_round = round_q;

  // Operands come only from registers, so g_res_valid never reaches g_a..g_d.
  for (genvar l = 0; l < NG; l++) begin : g_lane
    assign lane_g[l] = beat_q * NG3 + 3'(l);

    blake_g_mux #(.W(W)) u_mux (
      .v_i (v_flat),
      .g_i (lane_g[l]),
      .a_o (g_a[(NG-l)*W-1 -: W]),
      .b_o (g_b[(NG-l)*W-1 -: W]),
      .c_o (g_c[(NG-l)*W-1 -: W]),
      .d_o (g_d[(NG-l)*W-1 -: W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      beat_q  <= '0;
      for (int k = 0; k < 16; k++) v_q[k] <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      beat_q  <= beat_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (init_valid) state_d = ST_RUN;
      ST_RUN:  if (g_res_valid && last_beat && last_round) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-word write enables: lanes in one beat never share a word, so at most one lane hits each k.
  always_comb begin
    v_d     = v_q;
    round_d = round_q;
    beat_d  = beat_q;
    if ((state_q == ST_IDLE) && init_valid) begin
      for (int k = 0; k < 16; k++) v_d[k] = init_v[(16-k)*W-1 -: W];
      round_d = '0;
      beat_d  = '0;
    end else if (accept) begin
      for (int k = 0; k < 16; k++) begin
        for (int l = 0; l < NG; l++) begin
          if (g_word_idx(lane_g[l], 2'd0) == 4'(k)) v_d[k] = g_ra[(NG-l)*W-1 -: W];
          if (g_word_idx(lane_g[l], 2'd1) == 4'(k)) v_d[k] = g_rb[(NG-l)*W-1 -: W];
          if (g_word_idx(lane_g[l], 2'd2) == 4'(k)) v_d[k] = g_rc[(NG-l)*W-1 -: W];
          if (g_word_idx(lane_g[l], 2'd3) == 4'(k)) v_d[k] = g_rd[(NG-l)*W-1 -: W];
        end
      end
      if (last_beat) begin
        beat_d = '0;
        if (!last_round) round_d = round_q + 1'b1;
      end else begin
        beat_d = beat_q + 3'd1;
      end
    end
  end

  always_comb begin
    init_ready = (state_q == ST_IDLE);
    g_op_valid = (state_q == ST_RUN);
    out_valid  = (state_q == ST_DONE);
  end

endmodule
